// File: rtl/mod_video_timing.sv
// Pixel-timing master: raster counters plus registered active/sync/strobe flags
// derived from the next-state position so every output lines up with pix_x/pix_y.
module mod_video_timing #(
    parameter int unsigned H_ACTIVE         = 640,
    parameter int unsigned H_FP             = 16,
    parameter int unsigned H_SYNC           = 96,
    parameter int unsigned H_BP             = 48,
    parameter int unsigned V_ACTIVE         = 480,
    parameter int unsigned V_FP             = 10,
    parameter int unsigned V_SYNC           = 2,
    parameter int unsigned V_BP             = 33,
    parameter int unsigned SYNC_ACTIVE_HIGH = 0
) (
    input  logic       in_pix_clk,
    input  logic       in_reset,
    output logic [9:0] out_pix_x,
    output logic [9:0] out_pix_y,
    output logic       out_active,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_line_start,
    output logic       out_frame_latch,
    output logic [7:0] out_frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync region ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_ACT_END   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END   = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LATCH     = 10'(V_ACTIVE);
    localparam logic        SYNC_ON     = (SYNC_ACTIVE_HIGH != 0);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       frame_latch_q, frame_latch_d;
    logic [7:0] frame_count_q, frame_count_d;

    logic [10:0] x_ext, y_ext;

    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : (y_q + 10'd1);
        end

        x_ext = {1'b0, x_d};
        y_ext = {1'b0, y_d};

        active_d      = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
        hsync_d       = ((x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d       = ((y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
        line_start_d  = (x_d == '0);
        frame_latch_d = (x_d == '0) && (y_d == V_LATCH);
        frame_count_d = frame_count_q + {7'd0, frame_latch_d};
    end

    // Reset parks the raster on the last blank pixel so the first free edge lands on (0,0).
    always_ff @(posedge in_pix_clk) begin
        if (in_reset) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            line_start_q  <= 1'b0;
            frame_latch_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_latch_q <= frame_latch_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign out_pix_x       = x_q;
    assign out_pix_y       = y_q;
    assign out_active      = active_q;
    assign out_hsync       = hsync_q;
    assign out_vsync       = vsync_q;
    assign out_line_start  = line_start_q;
    assign out_frame_latch = frame_latch_q;
    assign out_frame_count = frame_count_q;

endmodule

// File: tb/tb_mod_video_timing.sv
// Bench for mod_video_timing: three raster geometries checked every cycle against
// an arithmetic model of position, flags and frame count versus elapsed cycles.
module tb_mod_video_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs t cycles after reset release (t < 0 means the reset state).
    function automatic logic [63:0] model(input int t, input int ha, input int hf, input int hs,
                                          input int hb, input int va, input int vf, input int vs,
                                          input int vb, input bit pol);
        int ht, vt, x, y, cnt;
        bit act, hsy, vsy, ls, fl;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (t < 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            x = t % ht;
            y = (t / ht) % vt;
        end
        act = (t >= 0) && (x < ha) && (y < va);
        hsy = (t >= 0) && (x >= ha + hf) && (x < ha + hf + hs);
        vsy = (t >= 0) && (y >= va + vf) && (y < va + vf + vs);
        ls  = (t >= 0) && (x == 0);
        fl  = (t >= 0) && (x == 0) && (y == va);
        cnt = (t >= ht * va) ? (((t - ht * va) / (ht * vt) + 1) % 256) : 0;
        return {31'd0, 10'(x), 10'(y), act, (hsy ? pol : !pol), (vsy ? pol : !pol), ls, fl, 8'(cnt)};
    endfunction

    function automatic logic [63:0] pack(input logic [9:0] x, input logic [9:0] y, input logic a,
                                         input logic h, input logic v, input logic l,
                                         input logic f, input logic [7:0] c);
        return {31'd0, x, y, a, h, v, l, f, c};
    endfunction

    // DUT A: default 800x525, active-low syncs
    logic rst_a = 1'b1;
    logic [9:0] a_x, a_y;
    logic a_act, a_hs, a_vs, a_ls, a_fl;
    logic [7:0] a_cnt;
    mod_video_timing dut_a (
        .in_pix_clk(clk), .in_reset(rst_a),
        .out_pix_x(a_x), .out_pix_y(a_y), .out_active(a_act),
        .out_hsync(a_hs), .out_vsync(a_vs), .out_line_start(a_ls),
        .out_frame_latch(a_fl), .out_frame_count(a_cnt)
    );

    // DUT B: tiny 24x7 raster, active-high syncs
    logic rst_b = 1'b1;
    logic [9:0] b_x, b_y;
    logic b_act, b_hs, b_vs, b_ls, b_fl;
    logic [7:0] b_cnt;
    mod_video_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE_HIGH(1)
    ) dut_b (
        .in_pix_clk(clk), .in_reset(rst_b),
        .out_pix_x(b_x), .out_pix_y(b_y), .out_active(b_act),
        .out_hsync(b_hs), .out_vsync(b_vs), .out_line_start(b_ls),
        .out_frame_latch(b_fl), .out_frame_count(b_cnt)
    );

    // DUT C: 48x27 raster, active-low syncs, scripted and random mid-frame resets
    logic rst_c = 1'b1;
    logic [9:0] c_x, c_y;
    logic c_act, c_hs, c_vs, c_ls, c_fl;
    logic [7:0] c_cnt;
    mod_video_timing #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_ACTIVE_HIGH(0)
    ) dut_c (
        .in_pix_clk(clk), .in_reset(rst_c),
        .out_pix_x(c_x), .out_pix_y(c_y), .out_active(c_act),
        .out_hsync(c_hs), .out_vsync(c_vs), .out_line_start(c_ls),
        .out_frame_latch(c_fl), .out_frame_count(c_cnt)
    );

    int t_a = -1;
    int t_b = -1;
    int t_c = -1;
    always @(posedge clk) begin
        t_a <= rst_a ? -1 : t_a + 1;
        t_b <= rst_b ? -1 : t_b + 1;
        t_c <= rst_c ? -1 : t_c + 1;
    end

    initial begin
        int lat_b;
        int c_phase;
        int c_hold;
        int exp_frames;
        lat_b   = 0;
        c_phase = 0;
        c_hold  = 0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("a_rst_x", 64'(a_x), 64'd799);
            check_eq("a_rst_y", 64'(a_y), 64'd524);
            check_eq("a_rst_act", 64'(a_act), 64'd0);
            check_eq("a_rst_hs", 64'(a_hs), 64'd1);
            check_eq("a_rst_vs", 64'(a_vs), 64'd1);
            check_eq("a_rst_misc", 64'({a_ls, a_fl, a_cnt}), 64'd0);
            check_eq("b_rst", pack(b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fl, b_cnt),
                     pack(10'd23, 10'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
            check_eq("c_rst", pack(c_x, c_y, c_act, c_hs, c_vs, c_ls, c_fl, c_cnt),
                     model(-1, 32, 4, 8, 4, 20, 2, 2, 3, 1'b0));
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        for (int cyc = 0; cyc < 43300; cyc++) begin
            @(negedge clk);
            check_eq("a_state", pack(a_x, a_y, a_act, a_hs, a_vs, a_ls, a_fl, a_cnt),
                     model(t_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            check_eq("b_state", pack(b_x, b_y, b_act, b_hs, b_vs, b_ls, b_fl, b_cnt),
                     model(t_b, 16, 2, 4, 2, 4, 1, 1, 1, 1'b1));
            check_eq("c_state", pack(c_x, c_y, c_act, c_hs, c_vs, c_ls, c_fl, c_cnt),
                     model(t_c, 32, 4, 8, 4, 20, 2, 2, 3, 1'b0));

            if (t_a == 0)
                check_eq("a_first", 64'({a_x, a_y, a_act, a_ls}), 64'({10'd0, 10'd0, 1'b1, 1'b1}));
            if (t_a == 639) check_eq("a_act_639", 64'(a_act), 64'd1);
            if (t_a == 640) check_eq("a_act_640", 64'(a_act), 64'd0);
            if (t_a == 656) check_eq("a_hs_656", 64'(a_hs), 64'd0);
            if (t_a == 752) check_eq("a_hs_752", 64'(a_hs), 64'd1);
            if (t_a == 800) check_eq("a_line1", 64'({a_x, a_y}), 64'({10'd0, 10'd1}));

            if (t_b == 18) check_eq("b_hs_18", 64'(b_hs), 64'd1);
            if (t_b == 22) check_eq("b_hs_22", 64'(b_hs), 64'd0);
            if (t_b == 5 * 24 + 3) check_eq("b_vs_y5", 64'(b_vs), 64'd1);
            if (b_fl === 1'b1) begin
                lat_b++;
                check_eq("b_latch_pos", 64'({b_x, b_y}), 64'({10'd0, 10'd4}));
                if (lat_b == 255) check_eq("b_cnt_255", 64'(b_cnt), 64'd255);
                if (lat_b == 256) check_eq("b_cnt_wrap", 64'(b_cnt), 64'd0);
            end

            case (c_phase)
                0: if (t_c == 990) begin
                    check_eq("c_pre_rst", 64'({c_x, c_y}), 64'({10'd30, 10'd20}));
                    c_hold  = 1;
                    c_phase = 1;
                end
                1: begin
                    check_eq("c_mid_rst", 64'({c_x, c_y, c_fl, c_cnt}),
                             64'({10'd47, 10'd26, 1'b0, 8'd0}));
                    c_phase = 2;
                end
                2: begin
                    check_eq("c_restart", 64'({c_x, c_y, c_fl}), 64'({10'd0, 10'd0, 1'b0}));
                    c_phase = 3;
                end
                default: if (c_hold == 0 && !rst_c && $urandom_range(0, 1999) == 0)
                    c_hold = $urandom_range(1, 4);
            endcase

            if (c_hold > 0) begin
                rst_c = 1'b1;
                c_hold--;
            end else begin
                rst_c = 1'b0;
            end
        end

        exp_frames = (t_b >= 96) ? ((t_b - 96) / 168 + 1) : 0;
        check_eq("b_latch_total", 64'(lat_b), 64'(exp_frames));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_video_timing.md
Name: mod_video_timing

Overview:
- Pixel-timing master that produces the scan-position interface consumed by the overlay modules: `pix_x`/`pix_y`, active-video flag, `hsync`/`vsync`, and a once-per-frame latch strobe.
- The latch strobe plus a frame counter feed the hex-display overlay, so debug values update only in vertical blank.
- Sits at the top of the video pipeline, clocked by the pixel clock, ahead of every overlay stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_HIGH, 0, 0 = sync pulses drive low, 1 = drive high

Ports:
- in_pix_clk  input  1  pixel clock; the only clock.
- in_reset  input  1  synchronous, active-high reset.
- out_pix_x  output  10  current horizontal count.
- out_pix_y  output  10  current vertical count.
- out_active  output  1  1 when x < H_ACTIVE and y < V_ACTIVE.
- out_hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH.
- out_vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_HIGH.
- out_line_start  output  1  one-cycle pulse when x == 0.
- out_frame_latch  output  1  one-cycle pulse at x == 0, y == V_ACTIVE (first blank line).
- out_frame_count  output  8  frames completed since reset, wraps.

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be ≤ 1024. Widths are fixed at 10 bits.
- All outputs are registers. No combinational path from input to output.
- All flags are computed from the next-state counter values, so they align on the same cycle as out_pix_x/out_pix_y. There is zero skew between position and flags.
- Horizontal counter: counts 0..H_TOTAL-1. After H_TOTAL-1 it goes to 0 and the vertical counter advances.
- Vertical counter: counts 0..V_TOTAL-1. After V_TOTAL-1 it goes to 0.
- Counters run through blanking; out_pix_x and out_pix_y report raw counts there (e.g. 700, 500), not clamped.
- hsync is asserted while H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync is asserted while V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491).
- Asserted level of both syncs is 1 if SYNC_ACTIVE_HIGH=1, else 0. Deasserted level is the inverse.
- out_line_start is 1 on every cycle where x == 0, for all lines including blank lines.
- out_frame_latch is 1 for exactly one cycle per frame, at (0, V_ACTIVE).
- out_frame_count increments on the same edge that raises out_frame_latch. A consumer latching on the strobe therefore captures the new count.
- out_frame_count wraps 255 → 0 with no flag.
- Reset, while in_reset = 1 at a clock edge:
  - x = H_TOTAL-1, y = V_TOTAL-1 (last pixel of the previous frame, blank).
  - out_active = 0, both syncs deasserted, out_line_start = 0, out_frame_latch = 0, out_frame_count = 0.
- Reset is held for N cycles: outputs are stable at the reset values the whole time.
- First edge after reset is released: x = 0, y = 0, out_active = 1, out_line_start = 1. Frame 0 starts cleanly, with no lost pixel.
- Reset asserted mid-frame: the next edge forces the reset state regardless of position. No partial pulses on latch or sync beyond that edge.
- Reset has priority over the counters' wrap logic.

Test Plan:
- Reset release: hold in_reset for 3 cycles, then release.
  - During reset: x = 799, y = 524, active = 0, hsync = vsync = 1 (SYNC_ACTIVE_HIGH = 0).
  - First cycle after release: x = 0, y = 0, active = 1, line_start = 1.
- Line timing on line 0:
  - active = 1 for x = 0..639 and 0 at x = 640.
  - hsync = 0 exactly for x = 656..751.
  - After x = 799, the next cycle shows x = 0, y = 1.
- Frame timing:
  - vsync = 0 only on lines 490 and 491.
  - frame_latch pulses once per frame at (0, 480); frame_count goes 0 → 1 on that cycle.
  - y wraps 524 → 0.
- Count wrap: run 256 frames. frame_count reads 255 after the 255th latch and 0 after the 256th, and latch still pulses every frame.
- Mid-frame reset:
  - Assert in_reset at (300, 200) for 1 cycle.
  - Next cycle shows (799, 524) with frame_count = 0; the following cycle shows (0, 0).
  - No extra frame_latch pulse.
- Polarity and size parameters: SYNC_ACTIVE_HIGH = 1 with H_ACTIVE = 16, H_FP = 2, H_SYNC = 4, H_BP = 2, V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1.
  - hsync = 1 for x = 18..21.
  - vsync = 1 on y = 5.
  - frame_latch pulses at (0, 4) every 24×7 = 168 cycles.
